// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: cache-miss freeze, load-use bubble, mispredict squash.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1_idx,
  input  logic [4:0]       id_rs2_idx,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_br_mispredict,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             imem_req_mask,
  output logic             dmem_req_mask,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t state_r, state_nxt_s;
  logic   i_done_r, d_done_r, i_done_nxt_s, d_done_nxt_s;
  logic   i_done_s, d_done_s;
  logic   i_pend_s, d_pend_s, freeze_s, hazard_s;
  logic   bubble_s, squash_s;

  // Sticky bits only carry meaning while frozen
  assign i_done_s = (state_r == STALL) & i_done_r;
  assign d_done_s = (state_r == STALL) & d_done_r;

  assign i_pend_s = imem_req & ~imem_resp & ~i_done_s;
  assign d_pend_s = dmem_req & ~dmem_resp & ~d_done_s;
  assign freeze_s = i_pend_s | d_pend_s;

  assign hazard_s = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1_idx == ex_rd)) |
                     (id_uses_rs2 & (id_rs2_idx == ex_rd)));

  assign squash_s = ~freeze_s & ex_br_mispredict;
  assign bubble_s = ~freeze_s & ~ex_br_mispredict & hazard_s;

  // State and sticky-response register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= RUN;
      i_done_r <= 1'b0;
      d_done_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      i_done_r <= i_done_nxt_s;
      d_done_r <= d_done_nxt_s;
    end
  end

  // Next state: freeze collects responses, any advance clears them
  always_comb begin
    state_nxt_s  = RUN;
    i_done_nxt_s = 1'b0;
    d_done_nxt_s = 1'b0;
    if (freeze_s) begin
      state_nxt_s  = STALL;
      i_done_nxt_s = i_done_s | imem_resp;
      d_done_nxt_s = d_done_s | dmem_resp;
    end else begin
      state_nxt_s  = RUN;
    end
  end

  // Load/flush decode; everything held low while reset is asserted
  always_comb begin
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst || freeze_s) begin
      load_pc = 1'b0;
    end else if (ex_br_mispredict) begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (hazard_s) begin
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      flush_id_ex = 1'b1;
    end else begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
    end
  end

  assign imem_req_mask = rst & i_done_s;
  assign dmem_req_mask = rst & d_done_s;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_r, bubble_r, flush_r;

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_r  <= {CNT_W{1'b0}};
      bubble_r <= {CNT_W{1'b0}};
      flush_r  <= {CNT_W{1'b0}};
    end else begin
      if (freeze_s && (stall_r != CNT_MAX)) stall_r <= stall_r + CNT_ONE;
      if (bubble_s && (bubble_r != CNT_MAX)) bubble_r <= bubble_r + CNT_ONE;
      if (squash_s && (flush_r != CNT_MAX)) flush_r <= flush_r + CNT_ONE;
    end
  end

  assign stall_cycles = stall_r;
  assign bubble_count = bubble_r;
  assign flush_count  = flush_r;
`else
  logic unused_s;
  assign unused_s     = bubble_s ^ squash_s;
  assign stall_cycles = {CNT_W{1'b0}};
  assign bubble_count = {CNT_W{1'b0}};
  assign flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. Each cycle it decides whether the PC and each inter-stage register (IF_ID, ID_EX, EX_MEM, MEM_WB) loads, holds, or loads a bubble. It freezes the whole pipeline across instruction-cache and data-cache misses, remembering which responses have already arrived. It inserts a single load-use bubble and squashes the two younger stages on a branch mispredict.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- imem_req  in  1  IF has an active instruction fetch
- imem_resp  in  1  I-cache response; one-cycle pulse
- dmem_req  in  1  MEM-stage instruction has an active load/store
- dmem_resp  in  1  D-cache response; one-cycle pulse
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination index of the EX instruction
- id_rs1_idx, id_rs2_idx  in  5 each  ID source indices
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1/rs2
- ex_br_mispredict  in  1  EX resolved branch/jump disagrees with prediction
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register load enables
- flush_if_id, flush_id_ex  out  1 each  with matching load: register captures a bubble (all-zero control, rd=0)
- imem_req_mask, dmem_req_mask  out  1 each  requester must gate its req low; the response is already consumed
- stall_cycles, bubble_count, flush_count  out  CNT_W each  performance counters

## Operation
- State: FSM {RUN, STALL} plus sticky bits i_done, d_done. All outputs are combinational from state, sticky bits and inputs (Mealy).
- i_pend = imem_req & ~imem_resp & ~i_done. d_pend = dmem_req & ~dmem_resp & ~d_done.
- Freeze cycle (i_pend | d_pend):
  - All load_* = 0 and flush_* = 0.
  - Next state is STALL.
  - i_done is set if imem_resp arrives. d_done is set if dmem_resp arrives.
- Advance cycle (no pending miss, from either state):
  - Next state is RUN and both sticky bits clear.
  - Loads follow the priority list below.
- Advance-cycle priority 1, ex_br_mispredict:
  - All loads = 1.
  - flush_if_id = 1 and flush_id_ex = 1.
  - The PC takes the redirect target.
- Advance-cycle priority 2, load-use hazard:
  - Condition: ex_mem_read & ex_rd≠0 & ((id_uses_rs1 & id_rs1_idx==ex_rd) | (id_uses_rs2 & id_rs2_idx==ex_rd)).
  - load_pc = 0 and load_if_id = 0.
  - load_id_ex = 1 with flush_id_ex = 1.
  - load_ex_mem = 1 and load_mem_wb = 1.
- Advance-cycle priority 3, otherwise: all loads = 1, no flush.
- imem_req_mask = i_done and dmem_req_mask = d_done. These stop a frozen requester from re-issuing a satisfied access.
- The cache interface holds rdata stable until the next req, so a response collected early stays valid for the advance edge.
- A mispredict or hazard seen during a freeze is ignored. The instruction stays in EX, so it is re-evaluated on the advance cycle.
- A request and response in the same cycle (hit) causes no freeze.
- Reset (asserted at any time, including mid-stall):
  - state = RUN, sticky bits 0, counters 0.
  - While rst is low, all load_*, flush_* and *_req_mask are forced to 0.

## Timing
- Zero-latency control: a decision made in cycle N takes effect at the clk edge ending cycle N.
- Miss stall duration equals the cycles until the last outstanding response. Responses arriving in different cycles are both honoured.
- A load-use hazard costs exactly 1 bubble cycle. A mispredict costs exactly 2 squashed slots.
- Reset assertion takes effect asynchronously. Deassertion is synchronised externally; first decision at the first clk edge after release.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles increments every freeze cycle.
  - bubble_count increments every load-use bubble.
  - flush_count increments every mispredict squash.
  - All counters saturate at all-ones.
- Undefined: no counter logic; the three counter outputs are tied to 0.

## Test plan
- imem_req=1, resp after 3 cycles, no dmem → 3 cycles of all loads 0, then all loads 1; stall_cycles=3.
- imem_resp in cycle 1 and dmem_resp in cycle 4 of a joint miss → imem_req_mask=1 in cycles 2–4; advance at end of cycle 4; sticky bits then 0.
- EX lw x5, ID add x6,x5,x1 → one cycle of load_pc=0, load_if_id=0, flush_id_ex=1; bubble_count=1.
- Mispredict coincident with a load-use hazard → flush_if_id=1, flush_id_ex=1, load_pc=1; no bubble counted; flush_count=1.
- Load-use with ex_rd=0, or with id_uses_rs1=0 → no bubble, all loads 1.
- rst pulled low mid-STALL with d_done=1 → outputs 0 immediately; after release, state RUN, masks 0, counters 0.
